// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encodings, bus address, quarter phases and frame size.
// Also used by the i2c_slave receiver on the far side of the AES link.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } i2c_state_t;

  localparam logic [6:0] I2C_ADDR_AES = 7'h6A;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Address byte plus 32 payload bytes.
  localparam int I2C_FRAME_BYTES = 33;

  function automatic logic [7:0] addr_wr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick divider: one-cycle tick every CLK_DIV enabled clocks, plus a
// wrapping 2-bit quarter counter; clear restarts both from zero on the next clock.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      quarter <= Q0;
    end else if (clear) begin
      cnt_q   <= '0;
      quarter <= Q0;
    end else if (enable) begin
      if (tick) begin
        cnt_q   <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// I2C write-only master: START, address byte, NUM_BYTES data bytes MSB-first, STOP;
// one frame per accepted start_req, aborts with STOP on any NACK; bus pins are registered.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 25,
  parameter int         NUM_BYTES  = I2C_FRAME_BYTES - 1,
  parameter logic [6:0] SLAVE_ADDR = I2C_ADDR_AES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_req,
  input  logic [8*NUM_BYTES-1:0] data_in,
  output logic                   scl,
  inout  wire                    sda,
  output logic                   busy,
  output logic                   done,
  output logic                   nack_err,
  output logic [5:0]             bytes_acked
);

  localparam int         SH_W       = 8 * (NUM_BYTES + 1);
  localparam logic [5:0] LAST_COUNT = 6'(NUM_BYTES + 1);

  i2c_state_t      state_q, state_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [SH_W-1:0] shreg_q;
  logic            abort_q;
  logic [5:0]      acked_q;
  logic            nack_q;
  logic            sda_meta_q, sda_sync_q;
  logic            scl_q, sda_oe_q;
  logic            scl_d, sda_oe_d;
  logic            tick;
  logic [1:0]      quarter;
  logic            accept;
  logic            shift_en;
  logic            ack_sample;
  logic            frame_end;

  assign accept = (state_q == ST_IDLE) && start_req;

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (busy),
    .tick    (tick),
    .quarter (quarter)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_en   = 1'b0;
    ack_sample = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) state_d = ST_START;
      end
      ST_START: begin
        if (tick && quarter == Q3) begin
          state_d   = ST_BIT;
          bit_idx_d = 3'd7;
        end
      end
      ST_BIT: begin
        if (tick && quarter == Q3) begin
          shift_en = 1'b1;
          if (bit_idx_q == 3'd0) state_d = ST_ACK;
          else bit_idx_d = bit_idx_q - 3'd1;
        end
      end
      ST_ACK: begin
        if (tick && quarter == Q2) ack_sample = 1'b1;
        // acked_q already includes this slot's ACK by q3.
        if (tick && quarter == Q3) begin
          if (abort_q || acked_q == LAST_COUNT) begin
            state_d = ST_STOP;
          end else begin
            state_d   = ST_BIT;
            bit_idx_d = 3'd7;
          end
        end
      end
      ST_STOP: begin
        if (tick && quarter == Q3) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus waveform per state and quarter; SDA only moves while SCL is low outside START/STOP.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      ST_START: begin
        scl_d    = (quarter != Q3);
        sda_oe_d = (quarter != Q0);
      end
      ST_BIT: begin
        scl_d    = (quarter == Q1) || (quarter == Q2);
        sda_oe_d = ~shreg_q[SH_W-1];
      end
      ST_ACK: begin
        scl_d = (quarter == Q1) || (quarter == Q2);
      end
      ST_STOP: begin
        scl_d    = (quarter != Q0);
        sda_oe_d = (quarter == Q0) || (quarter == Q1);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      shreg_q    <= '0;
      abort_q    <= 1'b0;
      acked_q    <= 6'd0;
      nack_q     <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      if (accept) begin
        shreg_q <= {addr_wr_byte(SLAVE_ADDR), data_in};
        abort_q <= 1'b0;
        acked_q <= 6'd0;
        nack_q  <= 1'b0;
      end else begin
        if (shift_en) shreg_q <= {shreg_q[SH_W-2:0], 1'b0};
        if (ack_sample) begin
          if (!sda_sync_q) acked_q <= acked_q + 6'd1;
          else abort_q <= 1'b1;
        end
        if (frame_end) nack_q <= abort_q;
      end
    end
  end

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign scl         = scl_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = frame_end;
  assign nack_err    = nack_q;
  assign bytes_acked = acked_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: a bus-level monitor/responder decodes START/STOP and bytes
// from the pins and is compared against a byte-list reference model of each frame.
module tb_i2c_master_tx;

  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;
  localparam int LIMIT   = 8000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_req;
  logic [255:0] data_in;
  logic         scl;
  wire          sda;
  logic         busy;
  logic         done;
  logic         nack_err;
  logic [5:0]   bytes_acked;

  int n_checks = 0;
  int n_pass   = 0;

  pullup (sda);
  logic resp_drive;
  assign sda = resp_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_tx #(
    .CLK_DIV    (CLK_DIV),
    .NUM_BYTES  (32),
    .SLAVE_ADDR (7'h6A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_req   (start_req),
    .data_in     (data_in),
    .scl         (scl),
    .sda         (sda),
    .busy        (busy),
    .done        (done),
    .nack_err    (nack_err),
    .bytes_acked (bytes_acked)
  );

  // Bus monitor and ACK responder, working purely from pin activity.
  int         nack_at = -1;
  logic [7:0] rx_q[$];
  int         n_start = 0, n_stop = 0, scl_rises = 0, idle_scl_falls = 0;
  int         bitn = 0, byte_idx = 0;
  logic [7:0] cur = 8'h00;
  logic       in_frame = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;

  always @(negedge clk) begin
    logic sda_v;
    sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (reset) begin
      resp_drive = 1'b0;
      bitn       = 0;
      in_frame   = 1'b0;
      scl_p      = 1'b1;
      sda_p      = 1'b1;
    end else begin
      if (scl && scl_p && sda_p && !sda_v) begin
        n_start++;
        in_frame = 1'b1;
        bitn     = 0;
        byte_idx = 0;
        rx_q.delete();
      end else if (scl && scl_p && !sda_p && sda_v) begin
        n_stop++;
        in_frame = 1'b0;
        bitn     = 0;
      end else if (scl && !scl_p) begin
        scl_rises++;
        if (bitn < 8) cur = {cur[6:0], sda_v};
        bitn++;
      end else if (!scl && scl_p) begin
        if (!in_frame) idle_scl_falls++;
        if (bitn == 8) begin
          resp_drive = (byte_idx != nack_at);
        end else if (bitn == 9) begin
          resp_drive = 1'b0;
          rx_q.push_back(cur);
          bitn = 0;
          byte_idx++;
        end
      end
      scl_p = scl;
      sda_p = sda_v;
    end
  end

  // Reference model: frame byte k (0 = address) and frame shape given the NACK position.
  function automatic logic [7:0] exp_byte(input logic [255:0] d, input int k);
    if (k == 0) return 8'hD4;
    return d[255-8*(k-1) -: 8];
  endfunction

  function automatic int exp_sent(input int nack);
    return (nack < 0) ? 33 : nack + 1;
  endfunction

  function automatic int exp_cycles(input int nack);
    return (2 + 9 * exp_sent(nack)) * SLOT;
  endfunction

  function automatic logic [255:0] rand_payload();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit bytes_match(input logic [255:0] d, input int nack);
    if (rx_q.size() != exp_sent(nack)) return 1'b0;
    for (int k = 0; k < rx_q.size(); k++)
      if (rx_q[k] !== exp_byte(d, k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [255:0] d, input int nack, input int pulse_at,
                           input logic [255:0] d2, output int cyc, output logic nk,
                           output logic [5:0] ba, output logic done_after,
                           output logic busy_after);
    nack_at = nack;
    @(negedge clk);
    data_in   = d;
    start_req = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start_req = 1'b0;
      if (cyc == pulse_at) begin
        start_req = 1'b1;
        data_in   = d2;
      end
      if (cyc == pulse_at + 1) start_req = 1'b0;
      if (done || cyc > LIMIT) break;
    end
    @(negedge clk);
    nk         = nack_err;
    ba         = bytes_acked;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    n_checks++;
    if (scl !== 1'b1) $display("FAIL reset_scl: got %b, required 1", scl); else n_pass++;
    n_checks++;
    if (sda !== 1'b1) $display("FAIL reset_sda: got %b, required 1 (released)", sda); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b, required 00", busy, done); else n_pass++;
    n_checks++;
    if (nack_err !== 1'b0 || bytes_acked !== 6'd0)
      $display("FAIL reset_status: got nack %b acked %0d, required 0 0", nack_err, bytes_acked);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    logic [255:0] d;
    int cyc, s0, p0, r0;
    logic nk, da, ba_b;
    logic [5:0] ba;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i);
      else d = rand_payload();
      s0 = n_start; p0 = n_stop; r0 = scl_rises;
      run_frame(d, -1, -1, '0, cyc, nk, ba, da, ba_b);
      n_checks++;
      if (cyc !== exp_cycles(-1)) $display("FAIL full_len[%0d]: got %0d clocks, required %0d", f, cyc, exp_cycles(-1)); else n_pass++;
      n_checks++;
      if (nk !== 1'b0 || ba !== 6'd33) $display("FAIL full_status[%0d]: got nack %b acked %0d, required 0 33", f, nk, ba); else n_pass++;
      n_checks++;
      if (da !== 1'b0 || ba_b !== 1'b0) $display("FAIL full_done_pulse[%0d]: got done %b busy %b after, required 0 0", f, da, ba_b); else n_pass++;
      n_checks++;
      if (!bytes_match(d, -1)) $display("FAIL full_bytes[%0d]: got %0d bytes, required 33 matching", f, rx_q.size()); else n_pass++;
      n_checks++;
      if (n_start - s0 != 1 || n_stop - p0 != 1 || scl_rises - r0 != 9 * 33 + 1)
        $display("FAIL full_bus[%0d]: got starts %0d stops %0d rises %0d, required 1 1 %0d",
                 f, n_start - s0, n_stop - p0, scl_rises - r0, 9 * 33 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_nack();
    int nacks[3];
    logic [255:0] d;
    int cyc, r0;
    logic nk, da, bb;
    logic [5:0] ba;
    nacks[0] = 0; nacks[1] = 5; nacks[2] = $urandom_range(1, 31);
    for (int j = 0; j < 3; j++) begin
      d  = rand_payload();
      r0 = scl_rises;
      run_frame(d, nacks[j], -1, '0, cyc, nk, ba, da, bb);
      n_checks++;
      if (cyc !== exp_cycles(nacks[j])) $display("FAIL nack_len[%0d]: got %0d clocks, required %0d", nacks[j], cyc, exp_cycles(nacks[j])); else n_pass++;
      n_checks++;
      if (nk !== 1'b1 || ba !== 6'(nacks[j])) $display("FAIL nack_status[%0d]: got nack %b acked %0d, required 1 %0d", nacks[j], nk, ba, nacks[j]); else n_pass++;
      n_checks++;
      if (!bytes_match(d, nacks[j]) || scl_rises - r0 != 9 * exp_sent(nacks[j]) + 1)
        $display("FAIL nack_bus[%0d]: got %0d bytes %0d rises, required %0d bytes %0d rises",
                 nacks[j], rx_q.size(), scl_rises - r0, exp_sent(nacks[j]), 9 * exp_sent(nacks[j]) + 1);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    logic [255:0] d, d2;
    int cyc, s0;
    logic nk, da, bb;
    logic [5:0] ba;
    d  = rand_payload();
    d2 = ~d;
    s0 = n_start;
    run_frame(d, -1, 100, d2, cyc, nk, ba, da, bb);
    n_checks++;
    if (!bytes_match(d, -1) || cyc !== exp_cycles(-1) || n_start - s0 != 1)
      $display("FAIL ignore_start: got %0d bytes %0d clocks %0d starts, required original 33 bytes %0d clocks 1 start",
               rx_q.size(), cyc, n_start - s0, exp_cycles(-1));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    int cyc, s0, w;
    logic nk, da, bb;
    logic [5:0] ba;
    nack_at = -1;
    @(negedge clk);
    data_in = rand_payload(); start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    w = 0;
    while (!(in_frame && byte_idx == 10 && bitn == 3) && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= LIMIT) $display("FAIL reset_mid_reach: got timeout after %0d clocks, required byte 10", w); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || bytes_acked !== 6'd0)
      $display("FAIL reset_mid_state: got scl %b sda %b busy %b acked %0d, required 1 1 0 0", scl, sda, busy, bytes_acked);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    d  = rand_payload();
    s0 = n_start;
    run_frame(d, -1, -1, '0, cyc, nk, ba, da, bb);
    n_checks++;
    if (!bytes_match(d, -1) || cyc !== exp_cycles(-1) || n_start - s0 != 1 || ba !== 6'd33)
      $display("FAIL reset_mid_restart: got %0d bytes %0d clocks %0d starts acked %0d, required 33 %0d 1 33",
               rx_q.size(), cyc, n_start - s0, ba, exp_cycles(-1));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [255:0] d1, d2;
    int cyc, s0, p0, g0;
    logic nk, da, bb;
    logic [5:0] ba;
    bit first_ok;
    d1 = rand_payload();
    d2 = rand_payload();
    s0 = n_start; p0 = n_stop; g0 = idle_scl_falls;
    nack_at = -1;
    @(negedge clk);
    data_in = d1; start_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start_req = 1'b0;
    end while (!done && cyc <= LIMIT);
    first_ok = bytes_match(d1, -1);
    @(negedge clk);
    data_in = d2; start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || cyc !== exp_cycles(-1))
      $display("FAIL b2b_accept: got busy %b first %0d clocks, required 1 %0d", busy, cyc, exp_cycles(-1));
    else n_pass++;
    cyc = 1;
    while (!done && cyc <= LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    n_checks++;
    if (!first_ok || !bytes_match(d2, -1) || cyc !== exp_cycles(-1))
      $display("FAIL b2b_bytes: got first_ok %0d second %0d bytes %0d clocks, required 1 33 %0d",
               first_ok, rx_q.size(), cyc, exp_cycles(-1));
    else n_pass++;
    n_checks++;
    if (n_start - s0 != 2 || n_stop - p0 != 2 || idle_scl_falls - g0 != 0)
      $display("FAIL b2b_bus: got starts %0d stops %0d idle scl falls %0d, required 2 2 0",
               n_start - s0, n_stop - p0, idle_scl_falls - g0);
    else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    start_req = 1'b0;
    data_in   = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_full_frame();
    test_nack();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
